traffic_input_conditioner: RTL and testbench

//  Upstream front end for the intersection light controller. Synchronises and debounces
//  the raw emergency, power-sense, pedestrian-button and left-turn-sensor inputs.

---
 rtl/traffic_input_conditioner.sv | 108 ++++++++++
 tb/tb_traffic_input_conditioner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_input_conditioner.sv
// Input front end for the intersection light controller: synchronises, debounces and
// conditions the emergency, power, pedestrian and left-turn inputs into controller requests.
module traffic_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int EMERG_HOLD      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       emergency_raw,
    input  logic       power_raw,
    input  logic       ped_raw,
    input  logic       left_raw,
    input  logic       ped_ack,
    input  logic       left_ack,
    output logic       Emergency,
    output logic       PowerOutage,
    output logic       Pedestrian,
    output logic       LeftTurn,
    output logic [3:0] deb_state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(EMERG_HOLD + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(EMERG_HOLD);

    // Channel order everywhere: bit 0 emerg, 1 power, 2 ped, 3 left.
    logic [3:0]                  raw_s;
    logic [3:0]                  rise_s;
    logic [3:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0][CW-1:0]          cnt_q, cnt_d;
    logic [3:0]                  deb_q, deb_d;
    logic [3:0]                  deb_prev_q, deb_prev_d;
    logic [HW-1:0]               hold_q, hold_d;
    logic                        emergency_q, emergency_d;
    logic                        power_q, power_d;
    logic                        ped_q, ped_d;
    logic                        left_q, left_d;

    assign raw_s  = {left_raw, ped_raw, power_raw, emergency_raw};
    assign rise_s = deb_q & ~deb_prev_q;

    // Synchroniser shift and debounce counter; deb only flips after a full stable run.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw_s[i]};
            deb_d[i]  = deb_q[i];
            cnt_d[i]  = {CW{1'b0}};
            if (sync_q[i][SYNC_STAGES-1] == deb_q[i]) begin
                cnt_d[i] = {CW{1'b0}};
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = ~deb_q[i];
                cnt_d[i] = {CW{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        deb_prev_d = deb_q;
    end

    // Request conditioning: emergency stretch with retrigger, set-dominant request latches.
    always_comb begin
        if (rise_s[0]) begin
            hold_d = HOLD_INIT;
        end else if (hold_q != {HW{1'b0}}) begin
            hold_d = hold_q - HW'(1);
        end else begin
            hold_d = hold_q;
        end
        emergency_d = (hold_d != {HW{1'b0}});
        power_d     = deb_q[1];
        ped_d       = rise_s[2] | (ped_q & ~ped_ack);
        left_d      = rise_s[3] | (left_q & ~left_ack);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            deb_q       <= 4'b0000;
            deb_prev_q  <= 4'b0000;
            hold_q      <= {HW{1'b0}};
            emergency_q <= 1'b0;
            power_q     <= 1'b0;
            ped_q       <= 1'b0;
            left_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_prev_d;
            hold_q      <= hold_d;
            emergency_q <= emergency_d;
            power_q     <= power_d;
            ped_q       <= ped_d;
            left_q      <= left_d;
        end
    end

    assign Emergency   = emergency_q;
    assign PowerOutage = power_q;
    assign Pedestrian  = ped_q;
    assign LeftTurn    = left_q;
    assign deb_state   = deb_q;

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Directed bench for traffic_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, EMERG_HOLD=8.
module tb_traffic_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       emergency_raw = 1'b0, power_raw = 1'b0, ped_raw = 1'b0, left_raw = 1'b0;
    logic       ped_ack = 1'b0, left_ack = 1'b0;
    logic       Emergency, PowerOutage, Pedestrian, LeftTurn;
    logic [3:0] deb_state;

    int n_cmp = 0;
    int n_bad = 0;

    traffic_input_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EMERG_HOLD(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .emergency_raw(emergency_raw), .power_raw(power_raw),
        .ped_raw(ped_raw), .left_raw(left_raw),
        .ped_ack(ped_ack), .left_ack(left_ack),
        .Emergency(Emergency), .PowerOutage(PowerOutage),
        .Pedestrian(Pedestrian), .LeftTurn(LeftTurn),
        .deb_state(deb_state)
    );

    always #5 clk = ~clk;

    // raw/exp bits are {left, ped, power, emerg}; ack is {left_ack, ped_ack}
    typedef struct {
        logic [3:0] raw;
        logic [1:0] ack;
        logic [3:0] exp_out;
        logic [3:0] exp_deb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] raw, logic [1:0] ack, logic [3:0] eo, logic [3:0] ed);
        vec_t v;
        v.raw = raw; v.ack = ack; v.exp_out = eo; v.exp_deb = ed;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        emergency_raw = 1'b0; power_raw = 1'b0; ped_raw = 1'b0; left_raw = 1'b0;
        ped_ack = 1'b0; left_ack = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] outs();
        return {LeftTurn, Pedestrian, PowerOutage, Emergency};
    endfunction

    initial begin
        int hi, first, rises, last;
        logic prev;

        // Test 1: ped held -> request at edge 7, held, cleared by ack.
        for (int k = 1; k <= 10; k++) begin
            vecs.push_back(mk(4'b0100, (k == 9) ? 2'b01 : 2'b00,
                              (k >= 7 && k <= 8) ? 4'b0100 : 4'b0000,
                              (k >= 6) ? 4'b0100 : 4'b0000));
        end
        // Test 5: power high 20 cycles, then low; ped level stays debounced high.
        for (int k = 1; k <= 20; k++) begin
            vecs.push_back(mk(4'b0110, 2'b00, (k >= 7) ? 4'b0010 : 4'b0000,
                              (k >= 6) ? 4'b0110 : 4'b0100));
        end
        for (int k = 1; k <= 12; k++) begin
            vecs.push_back(mk(4'b0100, 2'b00, (k >= 7) ? 4'b0000 : 4'b0010,
                              (k >= 6) ? 4'b0100 : 4'b0110));
        end

        do_reset();
        chk("reset_outs", 32'(outs()), 32'h0);
        chk("reset_deb", 32'(deb_state), 32'h0);

        foreach (vecs[i]) begin
            {left_raw, ped_raw, power_raw, emergency_raw} = vecs[i].raw;
            {left_ack, ped_ack} = vecs[i].ack;
            step();
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d_deb", i), 32'(deb_state), 32'(vecs[i].exp_deb));
        end

        // Test 2: bouncy ped input never debounces.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            ped_raw = (k <= 8) ? ((((k - 1) / 2) % 2) == 0) : 1'b0;
            step();
            chk($sformatf("bounce%0d_ped", k), 32'(Pedestrian), 32'h0);
            chk($sformatf("bounce%0d_deb", k), 32'(deb_state[2]), 32'h0);
        end

        // Test 3a: emergency level held 50 cycles -> one 8-cycle pulse starting at edge 7.
        do_reset();
        emergency_raw = 1'b1;
        hi = 0; first = -1; rises = 0; prev = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (Emergency) begin
                hi++;
                if (first < 0) first = k;
            end
            if (Emergency && !prev) rises++;
            prev = Emergency;
        end
        chk("emerg_first", 32'(first), 32'd7);
        chk("emerg_len", 32'(hi), 32'd8);
        chk("emerg_rises", 32'(rises), 32'd1);

        // Test 3b: second debounced rise before expiry reloads the hold.
        do_reset();
        hi = 0; first = -1; rises = 0; last = -1; prev = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            emergency_raw = (k <= 4) || (k >= 9);
            step();
            if (Emergency) begin
                hi++;
                last = k;
                if (first < 0) first = k;
            end
            if (Emergency && !prev) rises++;
            prev = Emergency;
        end
        chk("retrig_first", 32'(first), 32'd7);
        chk("retrig_last", 32'(last), 32'd22);
        chk("retrig_len", 32'(hi), 32'd16);
        chk("retrig_rises", 32'(rises), 32'd1);

        // Test 4: left rise coinciding with ack keeps the request.
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            left_raw = (k <= 4) || (k >= 9);
            step();
            if (k == 6) chk("left_e6", 32'(LeftTurn), 32'h0);
            if (k == 7) chk("left_e7", 32'(LeftTurn), 32'h1);
        end
        chk("left_e14", 32'(LeftTurn), 32'h1);
        chk("left_deb_e14", 32'(deb_state[3]), 32'h1);
        left_ack = 1'b1;
        step();
        chk("left_setwins", 32'(LeftTurn), 32'h1);
        left_ack = 1'b0;
        step();
        chk("left_hold", 32'(LeftTurn), 32'h1);
        left_ack = 1'b1;
        step();
        left_ack = 1'b0;
        chk("left_cleared", 32'(LeftTurn), 32'h0);
        left_ack = 1'b1;
        step();
        left_ack = 1'b0;
        step();
        chk("left_ack_idle", 32'(LeftTurn), 32'h0);

        // Test 6: mid-operation reset clears everything; ped re-detected after release.
        do_reset();
        ped_raw = 1'b1;
        emergency_raw = 1'b1;
        repeat (9) step();
        chk("pre_rst_outs", 32'(outs()), 32'b0101);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'(outs()), 32'h0);
        chk("async_rst_deb", 32'(deb_state), 32'h0);
        emergency_raw = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) chk("rel_e6_ped", 32'(Pedestrian), 32'h0);
        end
        chk("rel_e7_outs", 32'(outs()), 32'b0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
